// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with selectable fixed-priority or round-robin order.
// The round-robin pointer remembers the last winner and rotates the search downward from it.
module prio_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          mode,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic [IW-1:0] ptr
);

    logic [N-1:0]  gnt_r;
    logic          gnt_valid_r;
    logic [IW-1:0] gnt_idx_r;
    logic [IW-1:0] ptr_r;

    logic [IW-1:0] base_s;
    logic [IW-1:0] cand_s;
    logic [IW-1:0] win_idx_s;
    logic          win_found_s;
    logic          grant_s;
    logic [N-1:0]  gnt_next_s;

    // Search ptr-1 downward with wrap; fixed mode is the same search from base 0.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        cand_s      = {IW{1'b0}};
        if (mode) begin
            base_s = ptr_r;
        end else begin
            base_s = {IW{1'b0}};
        end
        for (int k = 1; k <= N; k++) begin
            cand_s = IW'((int'(base_s) + N - k) % N);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Gate the search result with the enable and form the one-hot grant.
    always_comb begin
        grant_s = en & win_found_s;
        if (grant_s) begin
            gnt_next_s = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
        end else begin
            gnt_next_s = {N{1'b0}};
        end
    end

    // Grant and pointer registers; the pointer only moves when a grant issues.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_r       <= {N{1'b0}};
            gnt_valid_r <= 1'b0;
            gnt_idx_r   <= {IW{1'b0}};
            ptr_r       <= {IW{1'b0}};
        end else begin
            gnt_r       <= gnt_next_s;
            gnt_valid_r <= grant_s;
            gnt_idx_r   <= grant_s ? win_idx_s : {IW{1'b0}};
            ptr_r       <= grant_s ? win_idx_s : ptr_r;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_idx   = gnt_idx_r;
    assign ptr       = ptr_r;

endmodule

// File: tb/tb_prio_arbiter.sv
// Scoreboard bench for prio_arbiter (N=4): directed vectors push hand-computed
// expectations, an independent monitor pops and compares each registered result.
module tb_prio_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clock;
    logic          reset;
    logic          en;
    logic          mode;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] ptr;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] ptr;
        logic [N-1:0]  req;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            passed = 0;
    logic [IW-1:0] exp_ptr = 2'd0;

    logic [N-1:0] sweep_exp [16] = '{
        4'b0000, 4'b0001, 4'b0010, 4'b0010,
        4'b0100, 4'b0100, 4'b0100, 4'b0100,
        4'b1000, 4'b1000, 4'b1000, 4'b1000,
        4'b1000, 4'b1000, 4'b1000, 4'b1000
    };

    prio_arbiter #(.N(N), .IW(IW)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .ptr       (ptr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
        idx_of = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) idx_of = IW'(i);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the result expected one edge later.
    task automatic step(input logic r, input logic e, input logic m,
                        input logic [N-1:0] rq, input logic [N-1:0] eg);
        exp_t x;
        @(negedge clock);
        reset = r;
        en    = e;
        mode  = m;
        req   = rq;
        if (r) exp_ptr = 2'd0;
        else if (eg != 4'b0000) exp_ptr = idx_of(eg);
        x.gnt = eg;
        x.ptr = exp_ptr;
        x.req = rq;
        exp_q.push_back(x);
    endtask

    // Monitor: after each rising edge, compare the registered outputs with the oldest expectation.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt",        32'(gnt),       32'(e.gnt));
            chk("gnt_valid",  32'(gnt_valid), 32'(|e.gnt));
            chk("gnt_idx",    32'(gnt_idx),   32'(idx_of(e.gnt)));
            chk("ptr",        32'(ptr),       32'(e.ptr));
            chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            chk("gnt_in_req", 32'((gnt & ~e.req) == 4'b0000), 32'd1);
        end
    end

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        req   = 4'b0000;

        // Reset overrides en/req
        step(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000);
        step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000);

        // Fixed-priority sweep
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'(i), sweep_exp[i]);
        end

        // Round-robin rotation from reset
        step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1000);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0100);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0010);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0001);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1000);

        // Round-robin skip from ptr=3
        step(1'b0, 1'b1, 1'b1, 4'b1001, 4'b0001);
        step(1'b0, 1'b1, 1'b1, 4'b1001, 4'b1000);

        // Enable gating in fixed mode
        step(1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b0110, 4'b0100);

        // Mode changes keep ptr
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0010);
        step(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1000);
        step(1'b0, 1'b1, 1'b1, 4'b0101, 4'b0100);

        // Single requester held in both modes
        step(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010);
        step(1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010);
        step(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010);

        // Mid-stream reset at ptr=2
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0001);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1000);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b0100);
        step(1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b1111, 4'b1000);

        // No grant cases hold ptr
        step(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000);

        @(negedge clock);
        en  = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
